// File: rtl/board_draw.sv
// board_draw: per-pixel drawing stage for one 10x10 battleship board.
// Three register stages turn VGA coordinates into board-cell indices and a
// tile ROM line address, consume the ROM line one clock later, and emit the
// board colour with the timing signals delayed by the same three clocks.
module board_draw #(
    parameter int unsigned X_POS    = 64,
    parameter int unsigned Y_POS    = 96,
    parameter int unsigned GRID     = 10,
    parameter logic [11:0] WATER    = 12'h05A,
    parameter logic [11:0] SHIP_C   = 12'h888,
    parameter logic [11:0] HIT_C    = 12'hF00,
    parameter logic [11:0] MISS_C   = 12'hFFF,
    parameter logic [11:0] CURSOR_C = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [3:0]  cell_col,
    output logic [3:0]  cell_row,
    input  logic [1:0]  cell_state,
    output logic [6:0]  rom_addr,
    input  logic [31:0] rom_line,
    input  logic        cursor_en,
    input  logic [3:0]  cursor_col,
    input  logic [3:0]  cursor_row,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // Board window limits; the upper bound is exclusive.
    localparam logic [10:0] X_LO  = 11'(X_POS);
    localparam logic [10:0] X_HI  = 11'(X_POS + 32 * GRID);
    localparam logic [10:0] Y_LO  = 11'(Y_POS);
    localparam logic [10:0] Y_HI  = 11'(Y_POS + 32 * GRID);
    // Only the low nine bits of the board-relative offset are ever used
    // (col = bits 8:5, px = bits 4:0), so the subtraction is kept 9 bits wide.
    localparam logic [8:0]  X_OFF = 9'(X_POS);
    localparam logic [8:0]  Y_OFF = 9'(Y_POS);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } timing_t;

    // ---------------- S1 state ----------------
    timing_t     tim_s1_d, tim_s1_q;
    logic [11:0] rgb_s1_d, rgb_s1_q;
    logic        in_board_s1_d, in_board_s1_q;
    logic [3:0]  col_s1_d, col_s1_q;
    logic [3:0]  row_s1_d, row_s1_q;
    logic [4:0]  px_s1_d, px_s1_q;
    logic [4:0]  py_s1_d, py_s1_q;
    logic [8:0]  dx, dy;

    // ---------------- S2 state ----------------
    timing_t     tim_s2_d, tim_s2_q;
    logic [11:0] rgb_s2_d, rgb_s2_q;
    logic        in_board_s2_d, in_board_s2_q;
    logic [4:0]  px_s2_d, px_s2_q;
    logic [4:0]  py_s2_d, py_s2_q;
    logic [1:0]  state_s2_d, state_s2_q;
    logic        cursor_hit_s2_d, cursor_hit_s2_q;

    // ---------------- S3 state ----------------
    timing_t     tim_s3_d, tim_s3_q;
    logic [11:0] rgb_s3_d, rgb_s3_q;
    logic        frame_px;
    logic        line_bit;

    // S1 next state: window test by comparison (never from dx/dy, so counts
    // left of or above the board cannot wrap into it) and cell/pixel split.
    always_comb begin
        tim_s1_d.hcount = hcount_in;
        tim_s1_d.vcount = vcount_in;
        tim_s1_d.hsync  = hsync_in;
        tim_s1_d.vsync  = vsync_in;
        tim_s1_d.hblnk  = hblnk_in;
        tim_s1_d.vblnk  = vblnk_in;
        rgb_s1_d        = rgb_in;
        in_board_s1_d   = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                          (vcount_in >= Y_LO) && (vcount_in < Y_HI);
        dx              = hcount_in[8:0] - X_OFF;
        dy              = vcount_in[8:0] - Y_OFF;
        col_s1_d        = '0;
        row_s1_d        = '0;
        px_s1_d         = '0;
        py_s1_d         = '0;
        if (in_board_s1_d) begin
            col_s1_d = dx[8:5];
            row_s1_d = dy[8:5];
            px_s1_d  = dx[4:0];
            py_s1_d  = dy[4:0];
        end
    end

    // Cell index to board-state memory and ROM line address from S1.
    // Each ROM row covers two screen lines, hence py[4:1].
    always_comb begin
        cell_col = col_s1_q;
        cell_row = row_s1_q;
        rom_addr = '0;
        if (in_board_s1_q) begin
            rom_addr = {cell_state, 1'b0, py_s1_q[4:1]};
        end
    end

    // S2 next state: carry S1 forward, capture cell state and cursor match.
    always_comb begin
        tim_s2_d        = tim_s1_q;
        rgb_s2_d        = rgb_s1_q;
        in_board_s2_d   = in_board_s1_q;
        px_s2_d         = px_s1_q;
        py_s2_d         = py_s1_q;
        state_s2_d      = cell_state;
        cursor_hit_s2_d = cursor_en && (col_s1_q == cursor_col) &&
                          (row_s1_q == cursor_row);
    end

    // S3 next state: colour priority blanking > outside > cursor > tile.
    always_comb begin
        tim_s3_d = tim_s2_q;
        frame_px = (px_s2_q == 5'd0) || (px_s2_q == 5'd31) ||
                   (py_s2_q == 5'd0) || (py_s2_q == 5'd31);
        // Leftmost pixel is the MSB: 31 - px equals ~px for a 5-bit px.
        line_bit = rom_line[~px_s2_q];
        rgb_s3_d = WATER;
        if (tim_s2_q.hblnk || tim_s2_q.vblnk) begin
            rgb_s3_d = '0;
        end else if (!in_board_s2_q) begin
            rgb_s3_d = rgb_s2_q;
        end else if (cursor_hit_s2_q && frame_px) begin
            rgb_s3_d = CURSOR_C;
        end else if (line_bit) begin
            unique case (state_s2_q)
                2'b01:   rgb_s3_d = SHIP_C;
                2'b10:   rgb_s3_d = HIT_C;
                2'b11:   rgb_s3_d = MISS_C;
                default: rgb_s3_d = WATER;
            endcase
        end
    end

    // All pipeline registers; asynchronous clear to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tim_s1_q        <= '0;
            rgb_s1_q        <= '0;
            in_board_s1_q   <= 1'b0;
            col_s1_q        <= '0;
            row_s1_q        <= '0;
            px_s1_q         <= '0;
            py_s1_q         <= '0;
            tim_s2_q        <= '0;
            rgb_s2_q        <= '0;
            in_board_s2_q   <= 1'b0;
            px_s2_q         <= '0;
            py_s2_q         <= '0;
            state_s2_q      <= '0;
            cursor_hit_s2_q <= 1'b0;
            tim_s3_q        <= '0;
            rgb_s3_q        <= '0;
        end else begin
            tim_s1_q        <= tim_s1_d;
            rgb_s1_q        <= rgb_s1_d;
            in_board_s1_q   <= in_board_s1_d;
            col_s1_q        <= col_s1_d;
            row_s1_q        <= row_s1_d;
            px_s1_q         <= px_s1_d;
            py_s1_q         <= py_s1_d;
            tim_s2_q        <= tim_s2_d;
            rgb_s2_q        <= rgb_s2_d;
            in_board_s2_q   <= in_board_s2_d;
            px_s2_q         <= px_s2_d;
            py_s2_q         <= py_s2_d;
            state_s2_q      <= state_s2_d;
            cursor_hit_s2_q <= cursor_hit_s2_d;
            tim_s3_q        <= tim_s3_d;
            rgb_s3_q        <= rgb_s3_d;
        end
    end

    // Output drive from the S3 registers.
    always_comb begin
        hcount_out = tim_s3_q.hcount;
        vcount_out = tim_s3_q.vcount;
        hsync_out  = tim_s3_q.hsync;
        vsync_out  = tim_s3_q.vsync;
        hblnk_out  = tim_s3_q.hblnk;
        vblnk_out  = tim_s3_q.vblnk;
        rgb_out    = rgb_s3_q;
    end

endmodule

// File: tb/tb_board_draw.sv
// Testbench for board_draw: scoreboard with a pixel-level reference model,
// a registered ROM model and a combinational board-state memory model.
module tb_board_draw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [3:0]  cell_col, cell_row;
    logic [1:0]  cell_state;
    logic [6:0]  rom_addr;
    logic [31:0] rom_line = '0;
    logic        cursor_en = 1'b0;
    logic [3:0]  cursor_col = '0, cursor_row = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    board_draw #(.X_POS(64), .Y_POS(96), .GRID(10)) dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .cell_col(cell_col), .cell_row(cell_row), .cell_state(cell_state),
        .rom_addr(rom_addr), .rom_line(rom_line),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memories modelled outside the DUT.
    logic [1:0]  board [0:9][0:9];
    logic [31:0] rom   [0:127];

    always_comb begin
        cell_state = 2'b00;
        if (cell_col < 4'd10 && cell_row < 4'd10) cell_state = board[cell_row][cell_col];
    end

    always @(posedge clk) rom_line <= rom[rom_addr];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [10:0] h;
        logic [10:0] v;
        logic [3:0]  tim;
        logic [11:0] rgb;
    } exp_t;
    exp_t q[$];

    // Reference: colour of one screen pixel from board/ROM/cursor contents.
    function automatic logic [11:0] ref_pixel(int h, int v, logic hb, logic vb, logic [11:0] bg);
        int col, row, px, py;
        logic [1:0]  st;
        logic [31:0] line;
        if (hb || vb) return 12'h000;
        if (h < 64 || h >= 64 + 320 || v < 96 || v >= 96 + 320) return bg;
        col = (h - 64) / 32;
        row = (v - 96) / 32;
        px  = (h - 64) % 32;
        py  = (v - 96) % 32;
        st  = board[row][col];
        if (cursor_en && col == int'(cursor_col) && row == int'(cursor_row) &&
            (px == 0 || px == 31 || py == 0 || py == 31)) return 12'hFF0;
        line = rom[int'(st) * 32 + py / 2];
        if (line[31 - px] && st != 2'b00) begin
            case (st)
                2'b01:   return 12'h888;
                2'b10:   return 12'hF00;
                default: return 12'hFFF;
            endcase
        end
        return 12'h05A;
    endfunction

    // Drive one pixel and queue its expected output.
    task automatic drive(input int h, input int v, input logic hs, input logic vs,
                         input logic hb, input logic vb, input logic [11:0] bg);
        exp_t e;
        @(posedge clk);
        #1;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = bg;
        e.cyc = cyc;
        e.h   = 11'(h);
        e.v   = 11'(v);
        e.tim = {hs, vs, hb, vb};
        e.rgb = ref_pixel(h, v, hb, vb, bg);
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rgb"}, 32'(rgb_out), 32'd0);
        chk({tag, "_hcount"}, 32'(hcount_out), 32'd0);
        chk({tag, "_vcount"}, 32'(vcount_out), 32'd0);
        chk({tag, "_timing"}, 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
        chk({tag, "_cell"}, 32'({cell_col, cell_row}), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    task automatic randomize_scene();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                board[r][c] = 2'($urandom_range(0, 3));
        for (int a = 0; a < 128; a++) rom[a] = $urandom;
        cursor_en  = 1'($urandom_range(0, 1));
        cursor_col = 4'($urandom_range(0, 9));
        cursor_row = 4'($urandom_range(0, 9));
    endtask

    function automatic int pick_coord(int lo, int hi);
        int r = int'($urandom_range(0, 9));
        if (r == 0) return lo - 1;
        if (r == 1) return lo;
        if (r == 2) return hi - 1;
        if (r == 3) return hi;
        if (r == 4) return int'($urandom_range(0, 2047));
        return int'($urandom_range(lo - 24, hi + 24));
    endfunction

    // Monitor: compare the DUT output against the oldest queued expectation
    // once that pixel has had three clocks to pass the pipeline.
    always @(negedge clk) begin
        if (!rst) begin
            while (q.size() != 0 && q[0].cyc + 3 <= cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("rgb_out", 32'(rgb_out), 32'(e.rgb));
                chk("hcount_out", 32'(hcount_out), 32'(e.h));
                chk("vcount_out", 32'(vcount_out), 32'(e.v));
                chk("timing_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(e.tim));
            end
        end
    end

    initial begin
        randomize_scene();
        // Reset held with active inputs.
        hcount_in = 11'd200; vcount_in = 11'd200; rgb_in = 12'hABC;
        hsync_in = 1'b1; vsync_in = 1'b1; cursor_en = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        drive(10, 10, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
        drive(11, 10, 1'b1, 1'b0, 1'b0, 1'b0, 12'h124);
        drive(12, 10, 1'b0, 1'b0, 1'b0, 1'b0, 12'h125);
        drain();

        // Address generation and hit decode in cell (3,2).
        board[2][3] = 2'b10;
        rom[7'h48]  = 32'hF003C00F;
        cursor_en   = 1'b0;
        drive(176, 176, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321);
        drive(177, 176, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321);
        chk("cell_col", 32'(cell_col), 32'd3);
        chk("cell_row", 32'(cell_row), 32'd2);
        chk("rom_addr", 32'(rom_addr), 32'h48);
        drive(178, 176, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321);
        drain();

        // Board edges.
        board[0][0] = 2'b01;
        rom[32]     = 32'hFFFFFFFF;
        drive(63, 200, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0C3);
        drive(64, 96, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0C3);
        drive(383, 200, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0C3);
        drive(384, 200, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0C3);
        drive(200, 415, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0C3);
        drive(200, 416, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0C3);
        drive(200, 95, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0C3);
        drive(2047, 2047, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0C3);
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0C3);
        drain();

        // Cursor frame on cell (0,0), miss state.
        board[0][0] = 2'b11;
        rom[98]     = 32'h80000001;
        cursor_en   = 1'b1;
        cursor_col  = 4'd0;
        cursor_row  = 4'd0;
        drive(64, 101, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
        drive(69, 101, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
        drive(95, 101, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
        drain();
        cursor_en = 1'b0;
        drive(64, 101, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
        drive(69, 101, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
        drive(95, 101, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
        drain();

        // Blanking inside the board.
        drive(100, 100, 1'b0, 1'b0, 1'b1, 1'b0, 12'h777);
        drive(100, 100, 1'b0, 1'b0, 1'b0, 1'b1, 12'h777);
        drain();

        // Randomised bursts with a fresh scene each time.
        for (int b = 0; b < 8; b++) begin
            randomize_scene();
            for (int i = 0; i < 250; i++) begin
                drive(pick_coord(64, 384), pick_coord(96, 416),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                      12'($urandom));
            end
            drain();
        end

        // Reset mid-line: pipeline clears at once and restarts after release.
        randomize_scene();
        for (int i = 0; i < 20; i++)
            drive(int'($urandom_range(64, 383)), int'($urandom_range(96, 415)),
                  1'b1, 1'b1, 1'b0, 1'b0, 12'($urandom));
        @(posedge clk);
        #3;
        rst = 1'b1;
        q.delete();
        #1;
        check_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++)
            drive(int'($urandom_range(64, 383)), int'($urandom_range(96, 415)),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 12'($urandom));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
